// File: rtl/video_pkg.sv
// Shared types and timing constants for the video output control blocks.
package video_pkg;

  typedef enum logic [1:0] {RUN, MUTE, RST, SETTLE} mode_state_t;

  localparam int unsigned SCREEN_WIDTH_640  = 640;
  localparam int unsigned SCREEN_HEIGHT_480 = 480;

  // Counter width that stays legal when the count is 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus consecutive-difference counter for the mode request.
module sync_debounce
  import video_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter bit          DEFAULT_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  input  logic committed_i,
  input  logic enable_i,
  output logic pending_o
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            req_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            differ;

  assign differ = (req_s_q != committed_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= DEFAULT_VAL;
      req_s_q <= DEFAULT_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      req_s_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || !differ) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Requires the request to still differ so a glitch ending on the last count is ignored.
  assign pending_o = enable_i && differ && (cnt_q == CntMax);

endmodule

// File: rtl/video_mode_switch_ctrl.sv
// Sequences HDMI/DVI mode changes: debounce, mute, wait for vblank, reset the
// video output while flipping the mode, then settle one frame before unmuting.
module video_mode_switch_ctrl
  import video_pkg::*;
#(
  parameter int unsigned SCREEN_HEIGHT   = SCREEN_HEIGHT_480,
  parameter bit          DEFAULT_DVI     = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MUTE_FRAMES     = 2,
  parameter int unsigned RESET_CYCLES    = 16
) (
  input  logic        clk_pixel_i,
  input  logic        reset_i,
  input  logic        mode_req_i,
  input  logic [11:0] cx_i,
  input  logic [10:0] cy_i,
  output logic        dvi_output_o,
  output logic        video_reset_o,
  output logic        rgb_mute_o,
  output logic        busy_o,
  output logic        vblank_start_o
);

  localparam int unsigned       FrameW    = $clog2(MUTE_FRAMES + 1);
  localparam int unsigned       RstW      = $clog2(RESET_CYCLES);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(MUTE_FRAMES - 1);
  localparam logic [RstW-1:0]   RstLast   = RstW'(RESET_CYCLES - 1);
  localparam logic [10:0]       VsLine    = 11'(SCREEN_HEIGHT);

  mode_state_t       state_q, state_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic              dvi_q, dvi_d;
  logic              vreset_q, vreset_d;
  logic              mute_q, mute_d;
  logic              busy_q, busy_d;
  logic              vreset_prev_q;
  logic              vblank_q;
  logic              vs;
  logic              pending;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DEFAULT_VAL     (DEFAULT_DVI)
  ) u_sync_debounce (
    .clk_i       (clk_pixel_i),
    .reset_i     (reset_i),
    .raw_i       (mode_req_i),
    .committed_i (dvi_q),
    .enable_i    (state_q == RUN),
    .pending_o   (pending)
  );

  // Coordinates are stale during the reset pulse and the cycle after it.
  assign vs = (cx_i == 12'd0) && (cy_i == VsLine) && !vreset_q && !vreset_prev_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    dvi_d       = dvi_q;
    vreset_d    = vreset_q;
    mute_d      = mute_q;
    unique case (state_q)
      RUN: begin
        // A coincident vs is deliberately not counted: one full muted frame is guaranteed.
        if (pending) begin
          state_d     = MUTE;
          mute_d      = 1'b1;
          frame_cnt_d = '0;
        end
      end
      MUTE: begin
        if (vs) begin
          if (frame_cnt_q == FrameLast) begin
            state_d   = RST;
            dvi_d     = ~dvi_q;
            vreset_d  = 1'b1;
            rst_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      RST: begin
        if (rst_cnt_q == RstLast) begin
          state_d  = SETTLE;
          vreset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (vs) begin
          state_d = RUN;
          mute_d  = 1'b0;
        end
      end
      default: state_d = RST;
    endcase
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) begin
      state_q       <= RST;
      frame_cnt_q   <= '0;
      rst_cnt_q     <= '0;
      dvi_q         <= DEFAULT_DVI;
      vreset_q      <= 1'b1;
      mute_q        <= 1'b1;
      busy_q        <= 1'b1;
      vreset_prev_q <= 1'b1;
      vblank_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      dvi_q         <= dvi_d;
      vreset_q      <= vreset_d;
      mute_q        <= mute_d;
      busy_q        <= busy_d;
      vreset_prev_q <= vreset_q;
      vblank_q      <= vs;
    end
  end

  assign dvi_output_o   = dvi_q;
  assign video_reset_o  = vreset_q;
  assign rgb_mute_o     = mute_q;
  assign busy_o         = busy_q;
  assign vblank_start_o = vblank_q;

endmodule
